compress_line_sequencer: RTL and testbench

//  Front-end controller for the 3-stage compression pipeline. Accepts 128-bit cache lines over valid/ready,

---
 rtl/compress_line_sequencer.sv | 150 +++++++++++++++
 tb/tb_compress_line_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/compress_line_sequencer.sv
// compress_line_sequencer
//   Front-end controller for the 3-stage compression pipeline. It takes one
//   128-bit cache line at a time and feeds it to the pipeline as two 64-bit
//   words on back-to-back cycles: low word first, then high word. It then waits
//   for the pipeline's finish strobe and captures the compressed line. If the
//   pipeline never finishes, a watchdog returns the raw line with o_out_raw=1.
//   The result is held on a valid/ready output until downstream accepts it.
//
//   Optional feature macro: COMPRESS_SEQ_STATS_EN
//     When defined, the block adds two saturating 16-bit counters:
//     o_lines_done (completed output handshakes) and o_timeouts (watchdog fires).
//
//   CACHE_LINE must equal 2*WIDTH.
module compress_line_sequencer #(
  parameter int CACHE_LINE     = 128,
  parameter int WIDTH          = 64,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_line_valid,
  output logic                  o_line_ready,
  input  logic [CACHE_LINE-1:0] i_line,
  output logic [WIDTH-1:0]      o_word,
  input  logic                  i_finish_final,
  input  logic [CACHE_LINE-1:0] i_mux_array2,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [CACHE_LINE-1:0] o_out_line,
  output logic                  o_out_raw,
`ifdef COMPRESS_SEQ_STATS_EN
  output logic [15:0]           o_lines_done,
  output logic [15:0]           o_timeouts,
`endif
  output logic                  o_busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FEED_LO = 3'd1,
    S_FEED_HI = 3'd2,
    S_WAIT    = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_MAX  = {CNT_W{1'b1}};

  state_t                state;
  state_t                state_nxt;
  logic [CACHE_LINE-1:0] line_q;
  logic [CNT_W-1:0]      watchdog;

  // Qualified events shared by the next-state logic and the datapath.
  logic accept;
  logic finish_hit;
  logic timeout_hit;
  logic out_take;

  assign accept      = (state == S_IDLE) && i_line_valid;
  assign finish_hit  = (state == S_WAIT) && i_finish_final;
  // When finish and timeout land in the same cycle, finish wins.
  assign timeout_hit = (state == S_WAIT) && !i_finish_final && (watchdog == WD_LAST);
  assign out_take    = (state == S_HOLD) && i_out_ready;

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!i_reset) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (accept) state_nxt = S_FEED_LO;
      S_FEED_LO: state_nxt = S_FEED_HI;
      S_FEED_HI: state_nxt = S_WAIT;
      S_WAIT:    if (finish_hit || timeout_hit) state_nxt = S_HOLD;
      S_HOLD:    if (out_take) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    o_line_ready = (state == S_IDLE);
    o_out_valid  = (state == S_HOLD);
    o_busy       = (state != S_IDLE);
  end

  // Datapath: line latch, word feed, watchdog and result capture.
  always_ff @(posedge i_clk or negedge i_reset) begin
    // NOTE: the wide data registers are reset as well, so a reset in the
    // middle of an operation discards the line and zeroes o_word at once.
    if (!i_reset) begin
      line_q     <= '0;
      o_word     <= '0;
      watchdog   <= '0;
      o_out_line <= '0;
      o_out_raw  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            line_q <= i_line;
            // Load the low word now so it is visible during FEED_LO.
            o_word <= i_line[WIDTH-1:0];
          end
        end
        S_FEED_LO: o_word <= line_q[CACHE_LINE-1:WIDTH];
        S_FEED_HI: begin
          o_word   <= '0;
          watchdog <= '0;
        end
        S_WAIT: begin
          // The watchdog saturates and never wraps.
          if (watchdog != WD_MAX) watchdog <= watchdog + CNT_W'(1);
          if (finish_hit) begin
            o_out_line <= i_mux_array2;
            o_out_raw  <= 1'b0;
          end else if (timeout_hit) begin
            o_out_line <= line_q;
            o_out_raw  <= 1'b1;
          end
        end
        default: ;  // HOLD: result registers stay stable
      endcase
    end
  end

`ifdef COMPRESS_SEQ_STATS_EN
  // Saturating counters for completed lines and watchdog fires.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_lines_done <= '0;
      o_timeouts   <= '0;
    end else begin
      if (out_take && (o_lines_done != 16'hFFFF)) o_lines_done <= o_lines_done + 16'd1;
      if (timeout_hit && (o_timeouts != 16'hFFFF)) o_timeouts <= o_timeouts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_compress_line_sequencer.sv
// Testbench for compress_line_sequencer. Randomized lines, finish timing and
// backpressure are checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_compress_line_sequencer;

  localparam int CL = 128;
  localparam int W  = 64;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          line_valid = 1'b0;
  logic          line_ready;
  logic [CL-1:0] line_in = '0;
  logic [W-1:0]  word;
  logic          finish = 1'b0;
  logic [CL-1:0] mux_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CL-1:0] out_line;
  logic          out_raw;
  logic          busy;
`ifdef COMPRESS_SEQ_STATS_EN
  logic [15:0]   lines_done;
  logic [15:0]   timeouts;
`endif

  int checks = 0;
  int errors = 0;
  int exp_done = 0;
  int exp_to = 0;

  compress_line_sequencer #(
    .CACHE_LINE(CL), .WIDTH(W), .TIMEOUT_CYCLES(TO), .CNT_W(5)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_line_valid  (line_valid),
    .o_line_ready  (line_ready),
    .i_line        (line_in),
    .o_word        (word),
    .i_finish_final(finish),
    .i_mux_array2  (mux_in),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_out_line    (out_line),
    .o_out_raw     (out_raw),
`ifdef COMPRESS_SEQ_STATS_EN
    .o_lines_done  (lines_done),
    .o_timeouts    (timeouts),
`endif
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [CL-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: a finish strobe on WAIT cycle 1..TO produces the
  // compressed line on that cycle; otherwise the raw line after TO cycles.
  function automatic bit model_raw(input int finish_at);
    return !(finish_at >= 1 && finish_at <= TO);
  endfunction

  function automatic int model_wait_cycles(input int finish_at);
    return model_raw(finish_at) ? TO : finish_at;
  endfunction

  task automatic check_stats(input string name);
`ifdef COMPRESS_SEQ_STATS_EN
    checks++;
    if (lines_done !== 16'(exp_done) || timeouts !== 16'(exp_to)) begin
      errors++;
      $display("FAIL %s stats got done=%0d to=%0d exp done=%0d to=%0d",
               name, lines_done, timeouts, exp_done, exp_to);
    end
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  // One full transaction: handshake, two words, wait, hold with stall, release.
  task automatic do_line(input string name, input logic [CL-1:0] line,
                         input logic [CL-1:0] mux, input int finish_at,
                         input int stall, input bit stray);
    bit            exp_raw;
    int            exp_c;
    logic [CL-1:0] exp_out;
    int            c;
    bit            got;
    exp_raw = model_raw(finish_at);
    exp_c   = model_wait_cycles(finish_at);
    exp_out = exp_raw ? line : mux;

    checks++;
    if (line_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle got ready=%b busy=%b exp ready=1 busy=0", name, line_ready, busy);
    end
    line_valid = 1'b1;
    line_in    = line;
    @(posedge clk); #1;
    line_valid = 1'b0;
    line_in    = rand_line();
    checks++;
    if (word !== line[W-1:0] || busy !== 1'b1 || line_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s word_lo got=%h busy=%b ready=%b exp=%h busy=1 ready=0",
               name, word, busy, line_ready, line[W-1:0]);
    end
    finish = stray;
    mux_in = rand_line();
    @(posedge clk); #1;
    checks++;
    if (word !== line[CL-1:W]) begin
      errors++;
      $display("FAIL %s word_hi got=%h exp=%h", name, word, line[CL-1:W]);
    end
    @(posedge clk); #1;
    finish = 1'b0;
    checks++;
    if (word !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s wait_entry got word=%h valid=%b exp word=0 valid=0", name, word, out_valid);
    end

    c   = 0;
    got = 1'b0;
    while (!got && c < 40) begin
      c++;
      finish = (c == finish_at);
      mux_in = (c == finish_at) ? mux : rand_line();
      @(posedge clk); #1;
      finish = 1'b0;
      if (out_valid === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || c != exp_c) begin
      errors++;
      $display("FAIL %s latency got=%0d exp=%0d (valid seen=%b)", name, c, exp_c, got);
    end
    checks++;
    if (out_line !== exp_out || out_raw !== exp_raw) begin
      errors++;
      $display("FAIL %s result got=%h raw=%b exp=%h raw=%b", name, out_line, out_raw, exp_out, exp_raw);
    end
    if (exp_raw) exp_to++;

    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      finish    = stray ? 1'b1 : 1'($urandom);
      mux_in    = rand_line();
      @(posedge clk); #1;
      finish = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_line !== exp_out || out_raw !== exp_raw || line_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold_stall%0d got valid=%b line=%h raw=%b ready=%b exp valid=1 line=%h raw=%b ready=0",
                 name, s, out_valid, out_line, out_raw, line_ready, exp_out, exp_raw);
      end
    end

    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_done++;
    checks++;
    if (out_valid !== 1'b0 || line_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s release got valid=%b ready=%b busy=%b exp valid=0 ready=1 busy=0",
               name, out_valid, line_ready, busy);
    end
    check_stats(name);
  endtask

  task automatic test_reset();
    logic [CL-1:0] l;
    #2;
    checks++;
    if (word !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || out_raw !== 1'b0 || out_line !== '0) begin
      errors++;
      $display("FAIL reset_state got word=%h valid=%b busy=%b raw=%b line=%h exp all zero",
               word, out_valid, busy, out_raw, out_line);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    // Reset asserted mid-FEED_HI must clear outputs asynchronously.
    l = rand_line();
    line_valid = 1'b1;
    line_in    = l;
    @(posedge clk); #1;
    line_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (word !== l[CL-1:W]) begin
      errors++;
      $display("FAIL reset_pre_hi got=%h exp=%h", word, l[CL-1:W]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (word !== '0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got word=%h valid=%b busy=%b exp 0 0 0", word, out_valid, busy);
    end
    exp_done = 0;
    exp_to   = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (line_ready !== 1'b1 || busy !== 1'b0 || word !== '0) begin
      errors++;
      $display("FAIL reset_release got ready=%b busy=%b word=%h exp ready=1 busy=0 word=0",
               line_ready, busy, word);
    end
    check_stats("reset_stats");
  endtask

  task automatic test_basic_finish();
    do_line("finish_c3", 128'h0123456789ABCDEF_FEDCBA9876543210, {16{8'hA5}}, 3, 0, 1'b0);
  endtask

  task automatic test_timeout();
    do_line("timeout", 128'h0123456789ABCDEF_FEDCBA9876543210, rand_line(), 0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_line("backpressure", rand_line(), rand_line(), 2, 5, 1'b1);
  endtask

  task automatic test_finish_last_cycle();
    do_line("finish_last", rand_line(), rand_line(), TO, 1, 1'b0);
    do_line("finish_late", rand_line(), rand_line(), TO + 1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      do_line($sformatf("rand%0d", i), rand_line(), rand_line(),
              int'($urandom_range(0, 20)), int'($urandom_range(0, 3)), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic_finish();
    test_timeout();
    test_backpressure();
    test_finish_last_cycle();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
